// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU: lane-wise wrap, saturating and Q-format arithmetic
// with per-lane NZCV flags, a sticky saturation flag and valid/ready flow control.
module simd_alu_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16,
  parameter int DATA_W = LANES * LANE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    result,
  output logic [4*LANES-1:0]   flags,
  output logic                 sat_sticky,
  input  logic                 clear_sat
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_LSR  = 4'b0011;
  localparam logic [3:0] OP_LSL  = 4'b0100;
  localparam logic [3:0] OP_ASR  = 4'b0101;
  localparam logic [3:0] OP_ADDS = 4'b0110;
  localparam logic [3:0] OP_SUBS = 4'b0111;
  localparam logic [3:0] OP_MULQ = 4'b1000;

  localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic                  s1_valid;
  logic [3:0]            s1_op;
  logic [DATA_W-1:0]     s1_a;
  logic [DATA_W-1:0]     s1_b;
  logic [2*DATA_W-1:0]   s1_prod;
  logic [2*DATA_W-1:0]   prod_in;
  logic [DATA_W-1:0]     res_next;
  logic [4*LANES-1:0]    flags_next;
  logic [LANES-1:0]      sat_lane;
  logic                  s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [2*LANE_W-1:0] pa, pb, p;
      logic [LANE_W-1:0]   la, lb, r;
      logic [LANE_W:0]     sum, diff;
      logic                add_v, sub_v, q_ovf, c, v, sat, op_ok;

      // Sign-extended operands so the low 2*LANE_W bits of the product are the signed product.
      assign pa = {{LANE_W{a[gi*LANE_W+LANE_W-1]}}, a[gi*LANE_W +: LANE_W]};
      assign pb = {{LANE_W{b[gi*LANE_W+LANE_W-1]}}, b[gi*LANE_W +: LANE_W]};
      assign prod_in[gi*2*LANE_W +: 2*LANE_W] = pa * pb;

      assign la = s1_a[gi*LANE_W +: LANE_W];
      assign lb = s1_b[gi*LANE_W +: LANE_W];
      assign p  = s1_prod[gi*2*LANE_W +: 2*LANE_W];

      assign sum   = {1'b0, la} + {1'b0, lb};
      assign diff  = {1'b0, la} + {1'b0, ~lb} + (LANE_W+1)'(1);
      assign add_v = (la[LANE_W-1] == lb[LANE_W-1]) && (sum[LANE_W-1] != la[LANE_W-1]);
      assign sub_v = (la[LANE_W-1] != lb[LANE_W-1]) && (diff[LANE_W-1] != la[LANE_W-1]);
      // Q result is p[2W-2:W-1]; it only fails to fit when the top two product bits differ (min*min).
      assign q_ovf = p[2*LANE_W-1] != p[2*LANE_W-2];

      always_comb begin
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        sat   = 1'b0;
        op_ok = 1'b1;
        case (s1_op)
          OP_ADD:  begin r = sum[LANE_W-1:0];  c = sum[LANE_W];  v = add_v; end
          OP_SUB:  begin r = diff[LANE_W-1:0]; c = diff[LANE_W]; v = sub_v; end
          OP_MUL:  r = p[LANE_W-1:0];
          OP_LSR:  r = la >> lb;
          OP_LSL:  r = la << lb;
          OP_ASR:  r = $signed(la) >>> lb;
          OP_ADDS: begin
            c = sum[LANE_W];
            v = add_v;
            sat = add_v;
            r = add_v ? (la[LANE_W-1] ? SMIN : SMAX) : sum[LANE_W-1:0];
          end
          OP_SUBS: begin
            c = diff[LANE_W];
            v = sub_v;
            sat = sub_v;
            r = sub_v ? (la[LANE_W-1] ? SMIN : SMAX) : diff[LANE_W-1:0];
          end
          OP_MULQ: begin
            v = q_ovf;
            sat = q_ovf;
            r = q_ovf ? (p[2*LANE_W-1] ? SMIN : SMAX) : p[2*LANE_W-2:LANE_W-1];
          end
          default: op_ok = 1'b0;
        endcase
      end

      assign res_next[gi*LANE_W +: LANE_W] = r;
      assign flags_next[gi*4 +: 4] = op_ok ? {r[LANE_W-1], ~|r, c, v} : 4'b0000;
      assign sat_lane[gi] = sat;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_prod  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_a    <= a;
        s1_b    <= b;
        s1_prod <= prod_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      result     <= '0;
      flags      <= '0;
      sat_sticky <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result <= res_next;
          flags  <= flags_next;
        end
      end
      // A saturating op landing in the output register beats a simultaneous clear.
      if (s2_load && s1_valid && |sat_lane)
        sat_sticky <= 1'b1;
      else if (clear_sat)
        sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: directed known answers plus random ops checked
// against an integer-arithmetic lane model; a separate monitor pops and compares.
module tb_simd_alu_pipe;
  localparam int LN = 4;
  localparam int LW = 16;

  typedef struct {
    logic [63:0] res;
    logic [15:0] flg;
    bit          sat;
    bit          chk_lat;
    int          issue;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [15:0] flags;
  logic        sat_sticky;
  logic        clear_sat;

  int   vectors = 0;
  int   misc = 0;
  int   cyc = 0;
  exp_t scb[$];
  int   pop_cyc[$];

  simd_alu_pipe #(.LANES(LN), .LANE_W(LW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags(flags), .sat_sticky(sat_sticky), .clear_sat(clear_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      misc++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Reference lane model: exact integer arithmetic, then wrap or clamp to LW bits.
  function automatic exp_t model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    longint ua, ub, sa, sbv, ex, r, m, hi, lo;
    bit c, v, s, ok;
    e.res = '0; e.flg = '0; e.sat = 1'b0; e.chk_lat = 1'b0; e.issue = 0;
    m  = (longint'(1) << LW) - 1;
    hi = (longint'(1) << (LW-1)) - 1;
    lo = -(hi + 1);
    for (int i = 0; i < LN; i++) begin
      ua  = longint'(x[i*LW +: LW]);
      ub  = longint'(y[i*LW +: LW]);
      sa  = (ua > hi) ? ua - (m + 1) : ua;
      sbv = (ub > hi) ? ub - (m + 1) : ub;
      c = 0; v = 0; s = 0; ok = 1; r = 0; ex = 0;
      case (o)
        4'd0: begin r = (ua + ub) & m; c = (ua + ub) > m; v = (sa + sbv > hi) || (sa + sbv < lo); end
        4'd1: begin r = (ua - ub) & m; c = ua >= ub; v = (sa - sbv > hi) || (sa - sbv < lo); end
        4'd2: r = (ua * ub) & m;
        4'd3: r = (ub >= LW) ? 0 : (ua >> ub);
        4'd4: r = (ub >= LW) ? 0 : ((ua << ub) & m);
        4'd5: r = (ub >= LW) ? ((sa < 0) ? m : 0) : ((sa >>> ub) & m);
        4'd6: begin
          ex = sa + sbv; c = (ua + ub) > m; v = (ex > hi) || (ex < lo); s = v;
          r = ((ex > hi) ? hi : ((ex < lo) ? lo : ex)) & m;
        end
        4'd7: begin
          ex = sa - sbv; c = ua >= ub; v = (ex > hi) || (ex < lo); s = v;
          r = ((ex > hi) ? hi : ((ex < lo) ? lo : ex)) & m;
        end
        4'd8: begin
          ex = (sa * sbv) >>> (LW-1); s = (ex > hi) || (ex < lo); v = s;
          r = ((ex > hi) ? hi : ((ex < lo) ? lo : ex)) & m;
        end
        default: ok = 0;
      endcase
      e.res[i*LW +: LW] = r[LW-1:0];
      if (ok) e.flg[4*i +: 4] = {r[LW-1], (r == 0), c, v};
      e.sat = e.sat | s;
    end
    return e;
  endfunction

  function automatic exp_t kat(input logic [63:0] res, input logic [15:0] flg, input bit sat);
    exp_t e;
    e.res = res; e.flg = flg; e.sat = sat; e.chk_lat = 1'b0; e.issue = 0;
    return e;
  endfunction

  function automatic logic [15:0] rlane();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      5: return 16'($urandom_range(0, 20));
      default: return 16'($urandom());
    endcase
  endfunction

  function automatic logic [63:0] rword();
    return {rlane(), rlane(), rlane(), rlane()};
  endfunction

  // Presents a request from a negedge until accepted; the expected response is queued then.
  task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                      input exp_t e_in, input bit lat, output int waits);
    exp_t e;
    e = e_in;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    forever begin
      #1;
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", 64'(waits), 64'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.chk_lat = lat;
    e.issue = cyc;
    scb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (scb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", 64'(scb.size()), 64'd0);
  endtask

  task automatic clear_pulse();
    @(negedge clk); clear_sat = 1'b1;
    @(negedge clk); clear_sat = 1'b0;
  endtask

  // Monitor: checks holds under stall, first-appearance latency, and pops on each transfer.
  initial begin
    bit          hold_pend = 1'b0;
    logic [63:0] held_res;
    logic [15:0] held_flg;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        hold_pend = 1'b0;
        continue;
      end
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", result, held_res);
        chk("hold_flags", 64'(flags), 64'(held_flg));
      end else if (out_valid && scb.size() != 0 && scb[0].chk_lat) begin
        chk("latency", 64'(cyc - scb[0].issue), 64'd2);
      end
      if (out_valid && out_ready) begin
        if (scb.size() == 0) begin
          vectors++; misc++;
          $display("FAIL spurious_output: got result 0x%0h, expected no output", result);
        end else begin
          e = scb.pop_front();
          chk("result", result, e.res);
          chk("flags", 64'(flags), 64'(e.flg));
          if (e.sat) chk("sticky_on_load", 64'(sat_sticky), 64'd1);
          pop_cyc.push_back(cyc);
        end
      end
      hold_pend = out_valid && !out_ready;
      held_res  = result;
      held_flg  = flags;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   w;
    exp_t e;
    bit   done;
    logic [63:0] x, y;
    logic [3:0]  o;
    int   r;

    reset = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    out_ready = 1'b1; clear_sat = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_sticky", 64'(sat_sticky), 64'd0);
    reset = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Known answers
    send(4'b0000, 64'h7FFF_0001_FFFF_0005, 64'h0001_0001_0001_FFFB,
         kat(64'h8000_0002_0000_0000, 16'h9066, 1'b0), 1'b1, w);
    drain();
    send(4'b0110, 64'h7FFF_0001_FFFF_0005, 64'h0001_0001_0001_FFFB,
         kat(64'h7FFF_0002_0000_0000, 16'h1066, 1'b1), 1'b1, w);
    drain();
    chk("sticky_set", 64'(sat_sticky), 64'd1);
    clear_pulse();
    #1 chk("sticky_clear", 64'(sat_sticky), 64'd0);
    send(4'b0110, 64'h7FFF_0001_FFFF_0005, 64'h0001_0001_0001_FFFB,
         kat(64'h7FFF_0002_0000_0000, 16'h1066, 1'b1), 1'b0, w);
    // clear_sat coincides with the edge that loads the saturating op into the output stage
    @(negedge clk); clear_sat = 1'b1;
    @(negedge clk); clear_sat = 1'b0;
    #1 chk("sticky_set_wins", 64'(sat_sticky), 64'd1);
    drain();
    clear_pulse();
    #1 chk("sticky_clear2", 64'(sat_sticky), 64'd0);
    send(4'b1000, 64'h4000_8000_C000_7FFF, 64'h4000_8000_4000_0001,
         kat(64'h2000_7FFF_E000_0000, 16'h0184, 1'b1), 1'b1, w);
    drain();
    chk("sticky_mulq", 64'(sat_sticky), 64'd1);

    send(4'b0101, 64'h8000, 64'd4,  kat(64'hF800, 16'h4448, 1'b0), 1'b0, w);
    send(4'b0101, 64'h8000, 64'd20, kat(64'hFFFF, 16'h4448, 1'b0), 1'b0, w);
    send(4'b0011, 64'h8000, 64'd16, kat(64'h0000, 16'h4444, 1'b0), 1'b0, w);
    send(4'b0100, 64'h0001, 64'd15, kat(64'h8000, 16'h4448, 1'b0), 1'b0, w);
    drain();

    // Backpressure: five back-to-back ADDs while the consumer stalls
    pop_cyc.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          x = rword(); y = rword();
          send(4'b0000, x, y, model(4'b0000, x, y), 1'b0, w);
          if (i < 2) chk("bp_no_wait", 64'(w), 64'd0);
          else if (i == 2) chk("bp_stalled", 64'(w > 0), 64'd1);
        end
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(pop_cyc.size()), 64'd5);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("bp_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Random traffic with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          r = $urandom_range(0, 11);
          o = (r <= 8) ? 4'(r) : 4'($urandom_range(9, 15));
          x = rword(); y = rword();
          send(o, x, y, model(o, x, y), 1'b0, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two ops in flight and the sticky flag set
    send(4'b0110, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001,
         model(4'b0110, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001), 1'b0, w);
    drain();
    @(negedge clk); out_ready = 1'b0;
    send(4'b0000, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001,
         model(4'b0000, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001), 1'b0, w);
    send(4'b0000, 64'h0002_0002_0002_0002, 64'h0001_0001_0001_0001,
         model(4'b0000, 64'h0002_0002_0002_0002, 64'h0001_0001_0001_0001), 1'b0, w);
    @(negedge clk);
    #3;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_sticky", 64'(sat_sticky), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sticky", 64'(sat_sticky), 64'd0);
    chk("async_rst_result", result, 64'd0);
    scb.delete();
    repeat (2) @(negedge clk);
    #3 reset = 1'b1; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    x = rword(); y = rword();
    send(4'b0001, x, y, model(4'b0001, x, y), 1'b1, w);
    drain();
    repeat (3) @(negedge clk);
    chk("post_rst_no_extra", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
